// File: rtl/crypt_pkg.sv
// crypt_pkg: shared widths and depths for the crypto core datapath.
package crypt_pkg;
    localparam int BYTE_W        = 8;
    localparam int RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: wrap-bit read/write pointers with empty/full flags, shared by the rx and tx FIFOs.
// Occupancy output o_count exists only when RX_FIFO_COUNT_EN is defined.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH)-1:0] o_wr_addr,
    output logic [$clog2(DEPTH)-1:0] o_rd_addr,
    output logic                     o_empty,
    output logic                     o_full
`ifdef RX_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   o_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    assign o_wr_addr = r_wr_ptr[AW-1:0];
    assign o_rd_addr = r_rd_ptr[AW-1:0];
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    // Full: same slot, opposite lap.
    assign o_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
`ifdef RX_FIFO_COUNT_EN
    assign o_count   = r_wr_ptr - r_rd_ptr;
`endif
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: host-to-control-unit byte FIFO with non-destructive registered peek and sticky overflow.
// Defining RX_FIFO_COUNT_EN adds the count occupancy port.
module rx_fifo
    import crypt_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int DEPTH  = RX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   read_fifo,
    input  logic                   rcv_deq,
    input  logic                   clear_overflow,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   emptyRx,
    output logic                   fullRx,
    output logic                   overflow
`ifdef RX_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_wr_addr, w_rd_addr;
    logic              w_push, w_pop, w_peek;
    assign w_pop  = rcv_deq && !emptyRx;
    // A same-cycle dequeue frees a slot, so a full FIFO still accepts the write.
    assign w_push = wr_en && (!fullRx || w_pop);
    assign w_peek = read_fifo && !emptyRx;
    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .o_wr_addr (w_wr_addr),
        .o_rd_addr (w_rd_addr),
        .o_empty   (emptyRx),
        .o_full    (fullRx)
`ifdef RX_FIFO_COUNT_EN
        ,
        .o_count   (count)
`endif
    );
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= w_peek;
            if (w_peek) rd_data <= r_mem[w_rd_addr];
            overflow <= (wr_en && !w_push) || (overflow && !clear_overflow);
        end
    end
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: table vectors plus a reference-queue scoreboard for rx_fifo.
module tb_rx_fifo;
    localparam int DEPTH = 16;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, read_fifo = 1'b0, rcv_deq = 1'b0, clear_overflow = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid, emptyRx, fullRx, overflow;
`ifdef RX_FIFO_COUNT_EN
    logic [4:0] count;
`endif
    int passed = 0, total = 0;
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    logic       model_ovf = 1'b0;
    logic       exp_valid = 1'b0;
    int         drained = 0;
    logic       saw_full = 1'b0;

    rx_fifo dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .read_fifo(read_fifo), .rcv_deq(rcv_deq), .clear_overflow(clear_overflow),
        .rd_data(rd_data), .rd_valid(rd_valid), .emptyRx(emptyRx), .fullRx(fullRx),
        .overflow(overflow)
`ifdef RX_FIFO_COUNT_EN
        , .count(count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic wr, input logic [7:0] d, input logic rf, input logic deq, input logic clr);
        logic pop, push;
        wr_en = wr; wr_data = d; read_fifo = rf; rcv_deq = deq; clear_overflow = clr;
        exp_valid = rf && model_q.size() > 0;
        if (exp_valid) exp_q.push_back(model_q[0]);
        pop  = deq && model_q.size() > 0;
        push = wr && (model_q.size() < DEPTH || pop);
        model_ovf = (wr && !push) ? 1'b1 : (clr ? 1'b0 : model_ovf);
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 0; read_fifo = 0; rcv_deq = 0; clear_overflow = 0;
        check("rd_valid", rd_valid, exp_valid);
        if (rd_valid) begin
            if (exp_q.size() == 0) check("unexpected_rd", 1, 0);
            else begin
                check("rd_data", rd_data, exp_q.pop_front());
                drained++;
            end
        end
        check("emptyRx", emptyRx, model_q.size() == 0);
        check("fullRx", fullRx, model_q.size() == DEPTH);
        check("overflow", overflow, model_ovf);
        if (fullRx) saw_full = 1'b1;
`ifdef RX_FIFO_COUNT_EN
        check("count", count, model_q.size());
`endif
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rf, deq, clr;
        logic       e, f, v;
        logic [7:0] rd;
        logic       ovf;
        int         cnt;
    } vec_t;
    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1};
        tbl[1]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3A, 1'b0, 2};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3A, 1'b0, 2};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b0, 1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b0, 0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b0, 0};
        tbl[8]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5C, 1'b0, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_empty", emptyRx, 1);
        check("rst_full", fullRx, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdata", rd_data, 8'h00);
`ifdef RX_FIFO_COUNT_EN
        check("rst_count", count, 0);
`endif

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].wr, tbl[i].d, tbl[i].rf, tbl[i].deq, tbl[i].clr);
            check($sformatf("vec%0d_empty", i), emptyRx, tbl[i].e);
            check($sformatf("vec%0d_full", i), fullRx, tbl[i].f);
            check($sformatf("vec%0d_valid", i), rd_valid, tbl[i].v);
            check($sformatf("vec%0d_rdata", i), rd_data, tbl[i].rd);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
`ifdef RX_FIFO_COUNT_EN
            check($sformatf("vec%0d_count", i), count, tbl[i].cnt);
`endif
        end

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        check("fill_full", fullRx, 1);
        cyc(1, 8'hFF, 0, 0, 0);
        check("drop_ovf", overflow, 1);
        check("drop_full", fullRx, 1);
        drained = 0;
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 1, 0);
        check("drain_n", drained, 16);
        check("drain_empty", emptyRx, 1);
        check("ovf_sticky", overflow, 1);
        cyc(0, 8'h00, 0, 0, 1);
        check("ovf_clear", overflow, 0);

        // Write and dequeue together while full.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'hAA, 0, 1, 0);
        check("wrdeq_full", fullRx, 1);
        check("wrdeq_ovf", overflow, 0);
        drained = 0;
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 1, 0);
        check("wrdeq_last", rd_data, 8'hAA);
        check("wrdeq_n", drained, 16);

        // Interleaved traffic across the pointer wrap.
        saw_full = 1'b0;
        drained = 0;
        cyc(1, 8'h00, 0, 0, 0);
        for (int i = 1; i < 40; i++) cyc(1, 8'(i), 1, 1, 0);
        cyc(0, 8'h00, 1, 1, 0);
        check("wrap_n", drained, 40);
        check("wrap_nofull", saw_full, 0);
        check("wrap_empty", emptyRx, 1);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
        check("pre_rst_empty", emptyRx, 0);
        #3 reset = 1'b1;
        #1;
        check("async_empty", emptyRx, 1);
        check("async_full", fullRx, 0);
        check("async_valid", rd_valid, 0);
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 8'h00, 1, 0, 0);
        check("post_rst_valid", rd_valid, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
